// File: rtl/uart_pkg.sv
// uart_pkg: UART framing constants, TX state encoding and frame builder shared by TX and RX
package uart_pkg;
   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS = 8;
   localparam int OVERSAMPLE_DEF = 16;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
   // {stop, parity, data, start}; bit 0 goes on the line first
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d, input logic odd);
      return {1'b1, ^d ^ odd, d, 1'b0};
   endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: modulo-OVERSAMPLE baud counter with synchronous clear and end-of-bit strobe
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   localparam int TW = $clog2(OVERSAMPLE)
) (
   input  logic          baud_clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [TW-1:0] cnt,
   output logic          bit_end
);
   assign bit_end = en && cnt == TW'(OVERSAMPLE - 1);
   always_ff @(posedge baud_clk)
      cnt <= (!rst_n || clr || bit_end) ? '0 : cnt + TW'(en);
endmodule

// File: rtl/uart_tx_piso.sv
// uart_tx_piso: valid/ready byte in, 11-bit start/data/parity/stop frame out on data_tx
module uart_tx_piso
   import uart_pkg::*;
#(
   parameter int   OVERSAMPLE = OVERSAMPLE_DEF,
   parameter logic PARITY_ODD = 1'b0
) (
   input  logic                 baud_clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 data_tx,
   output logic                 active_flag,
   output logic                 tx_done
);
   localparam int TW = $clog2(OVERSAMPLE);
   tx_state_e             state;
   logic [DATA_BITS-1:0]  hold;
   logic [FRAME_BITS-2:0] sh;
   logic [FRAME_BITS-1:0] frame;
   logic [2:0]            idx;
   logic [TW-1:0]         cnt;
   logic                  hold_full, bit_end, accept, final_stop, direct, load;
   assign tx_ready = !hold_full;
   assign accept = tx_valid && tx_ready;
   assign final_stop = state == STOP && bit_end;
   // the final stop cycle counts as idle so a fresh byte starts with zero gap
   assign direct = accept && (state == IDLE || final_stop);
   assign load = direct || (final_stop && hold_full);
   assign frame = build_frame(direct ? tx_data : hold, PARITY_ODD);
   uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
      .baud_clk(baud_clk),
      .rst_n(rst_n),
      .clr(state == IDLE),
      .en(state != IDLE),
      .cnt(cnt),
      .bit_end(bit_end)
   );
   always_ff @(posedge baud_clk) begin
      if (!rst_n) begin
         state <= IDLE;
         hold <= '0;
         hold_full <= 1'b0;
         sh <= '0;
         idx <= '0;
         data_tx <= 1'b1;
         active_flag <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= state == STOP && cnt == TW'(OVERSAMPLE - 2);
         if (accept && !direct) begin
            hold <= tx_data;
            hold_full <= 1'b1;
         end
         if (load) begin
            state <= START;
            sh <= frame[FRAME_BITS-1:1];
            data_tx <= frame[0];
            active_flag <= 1'b1;
            if (!direct) hold_full <= 1'b0;
         end else if (bit_end) begin
            data_tx <= state == STOP ? 1'b1 : sh[0];
            sh <= sh >> 1;
            case (state)
               START: state <= DATA;
               DATA: begin
                  idx <= idx + 3'd1;
                  if (idx == 3'(DATA_BITS - 1)) state <= PARITY;
               end
               PARITY: state <= STOP;
               STOP: begin
                  state <= IDLE;
                  active_flag <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_piso.sv
// tb_uart_tx_piso: three transmitter variants against a frame-level reference model plus directed vectors
module tb_uart_tx_piso;
   logic baud_clk = 1'b0;
   logic rst_n, tx_valid;
   logic [7:0] tx_data;
   logic d_tx[3], d_act[3], d_done[3], d_rdy[3];
   int total = 0, bad = 0;
   logic chk_en = 1'b0;

   always #5 baud_clk = ~baud_clk;

   uart_tx_piso #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut_e (.baud_clk(baud_clk), .rst_n(rst_n), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(d_rdy[0]), .data_tx(d_tx[0]), .active_flag(d_act[0]), .tx_done(d_done[0]));
   uart_tx_piso #(.OVERSAMPLE(16), .PARITY_ODD(1'b1)) dut_o (.baud_clk(baud_clk), .rst_n(rst_n), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(d_rdy[1]), .data_tx(d_tx[1]), .active_flag(d_act[1]), .tx_done(d_done[1]));
   uart_tx_piso #(.OVERSAMPLE(4), .PARITY_ODD(1'b0)) dut_4 (.baud_clk(baud_clk), .rst_n(rst_n), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(d_rdy[2]), .data_tx(d_tx[2]), .active_flag(d_act[2]), .tx_done(d_done[2]));

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
      end
   endtask

   task automatic chkv(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // reference model: per-cycle line waveform queue plus pending byte queue
   int os_p[3] = '{16, 16, 4};
   logic odd_p[3] = '{1'b0, 1'b1, 1'b0};
   logic wave[3][$];
   logic [7:0] pend[3][$];
   logic e_tx[3], e_act[3], e_done[3], e_rdy[3];
   logic [7:0] mb;
   logic [10:0] mf;

   always @(posedge baud_clk)
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            wave[d].delete();
            pend[d].delete();
            e_tx[d] = 1'b1;
            e_act[d] = 1'b0;
            e_done[d] = 1'b0;
         end else begin
            if (tx_valid && pend[d].size() == 0) pend[d].push_back(tx_data);
            if (wave[d].size() == 0 && pend[d].size() != 0) begin
               mb = pend[d].pop_front();
               mf = {1'b1, ^mb ^ odd_p[d], mb, 1'b0};
               for (int i = 0; i < 11; i++)
                  for (int r = 0; r < os_p[d]; r++) wave[d].push_back(mf[i]);
            end
            if (wave[d].size() != 0) begin
               e_tx[d] = wave[d].pop_front();
               e_act[d] = 1'b1;
               e_done[d] = wave[d].size() == 0;
            end else begin
               e_tx[d] = 1'b1;
               e_act[d] = 1'b0;
               e_done[d] = 1'b0;
            end
         end
         e_rdy[d] = pend[d].size() == 0;
      end

   always @(negedge baud_clk)
      if (chk_en)
         for (int d = 0; d < 3; d++) begin
            chk1($sformatf("model_tx%0d", d), d_tx[d], e_tx[d]);
            chk1($sformatf("model_act%0d", d), d_act[d], e_act[d]);
            chk1($sformatf("model_done%0d", d), d_done[d], e_done[d]);
            chk1($sformatf("model_rdy%0d", d), d_rdy[d], e_rdy[d]);
         end

   typedef struct {
      logic [7:0]  data;
      logic [10:0] even_f;
      logic [10:0] odd_f;
   } vec_t;
   vec_t vec[5];
   logic [10:0] rx_e, rx_o, rx_4;
   int done16, done4, ndone16, k, n_done, n_act, first_act, last_act;
   logic acc, saw_busy;
   logic [7:0] seq[3];

   initial begin
      rst_n = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      repeat (3) @(negedge baud_clk);
      for (int d = 0; d < 3; d++) begin
         chk1($sformatf("rst_tx%0d", d), d_tx[d], 1'b1);
         chk1($sformatf("rst_act%0d", d), d_act[d], 1'b0);
         chk1($sformatf("rst_done%0d", d), d_done[d], 1'b0);
         chk1($sformatf("rst_rdy%0d", d), d_rdy[d], 1'b1);
      end
      rst_n = 1'b1;
      chk_en = 1'b1;

      vec[0] = '{8'hA5, 11'b1_0_1010_0101_0, 11'b1_1_1010_0101_0};
      vec[1] = '{8'h01, 11'b1_1_0000_0001_0, 11'b1_0_0000_0001_0};
      vec[2] = '{8'h3C, 11'b1_0_0011_1100_0, 11'b1_1_0011_1100_0};
      vec[3] = '{8'hFF, 11'b1_0_1111_1111_0, 11'b1_1_1111_1111_0};
      vec[4] = '{8'h00, 11'b1_0_0000_0000_0, 11'b1_1_0000_0000_0};
      for (int v = 0; v < 5; v++) begin
         @(negedge baud_clk);
         tx_data = vec[v].data;
         tx_valid = 1'b1;
         @(negedge baud_clk);
         tx_valid = 1'b0;
         tx_data = ~vec[v].data;
         rx_e = '0; rx_o = '0; rx_4 = '0;
         done16 = 0; done4 = 0; ndone16 = 0;
         for (int j = 1; j <= 190; j++) begin
            if (j > 1) @(negedge baud_clk);
            if ((j - 1) % 16 == 8 && j <= 176) begin
               rx_e[(j - 1) / 16] = d_tx[0];
               rx_o[(j - 1) / 16] = d_tx[1];
            end
            if ((j - 1) % 4 == 2 && j <= 44) rx_4[(j - 1) / 4] = d_tx[2];
            if (d_done[0]) begin done16 = j; ndone16++; end
            if (d_done[2]) done4 = j;
         end
         chkv($sformatf("frame_even_%0h", vec[v].data), int'(rx_e), int'(vec[v].even_f));
         chkv($sformatf("frame_odd_%0h", vec[v].data), int'(rx_o), int'(vec[v].odd_f));
         chkv($sformatf("frame_os4_%0h", vec[v].data), int'(rx_4), int'(vec[v].even_f));
         chkv("done_cycle16", done16, 176);
         chkv("done_count16", ndone16, 1);
         chkv("done_cycle4", done4, 44);
      end

      seq = '{8'h55, 8'hAA, 8'h0F};
      @(negedge baud_clk);
      k = 0; n_done = 0; n_act = 0; first_act = -1; last_act = -1; saw_busy = 1'b0;
      tx_data = seq[0];
      tx_valid = 1'b1;
      for (int c = 0; c < 620; c++) begin
         acc = tx_valid && d_rdy[0];
         @(negedge baud_clk);
         if (acc) begin
            k++;
            if (k < 3) tx_data = seq[k];
            else tx_valid = 1'b0;
         end
         n_done += int'(d_done[0]);
         if (d_act[0]) begin
            n_act++;
            if (first_act < 0) first_act = c;
            last_act = c;
         end
         if (!d_rdy[0]) saw_busy = 1'b1;
      end
      tx_valid = 1'b0;
      chkv("b2b_accepts", k, 3);
      chkv("b2b_done_pulses", n_done, 3);
      chkv("b2b_active_cycles", n_act, 528);
      chkv("b2b_no_gap", last_act - first_act + 1, 528);
      chk1("b2b_ready_low_seen", saw_busy, 1'b1);

      @(negedge baud_clk);
      tx_data = 8'h81;
      tx_valid = 1'b1;
      @(negedge baud_clk);
      tx_data = 8'h7E;
      @(negedge baud_clk);
      tx_valid = 1'b0;
      repeat (77) @(negedge baud_clk);
      chk1("mid_hold_full", d_rdy[0], 1'b0);
      rst_n = 1'b0;
      @(negedge baud_clk);
      rst_n = 1'b1;
      chk1("mid_rst_tx", d_tx[0], 1'b1);
      chk1("mid_rst_rdy", d_rdy[0], 1'b1);
      n_done = 0; n_act = 0;
      repeat (400) begin
         @(negedge baud_clk);
         n_done += int'(d_done[0]);
         n_act += int'(d_act[0]);
      end
      chkv("mid_rst_no_done", n_done, 0);
      chkv("mid_rst_no_resend", n_act, 0);

      for (int c = 0; c < 5000; c++) begin
         @(negedge baud_clk);
         tx_valid = $urandom_range(0, 5) == 0;
         if (tx_valid || $urandom_range(0, 1) == 0) tx_data = 8'($urandom);
         rst_n = $urandom_range(0, 2999) != 0;
      end
      tx_valid = 1'b0;
      rst_n = 1'b1;
      repeat (400) @(negedge baud_clk);
      for (int d = 0; d < 3; d++) chk1($sformatf("final_idle%0d", d), d_tx[d], 1'b1);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_piso.md
# uart_tx_piso

Parallel-in/serial-out UART transmitter, the transmit-side counterpart of the team's oversampling SIPO receiver. It accepts an 8-bit byte over a valid/ready handshake and serialises it onto `data_tx` as an 11-bit frame: start, 8 data bits LSB-first, parity, stop. The frame matches exactly what the receiver assembles into `data_parll[10:0]`. A one-entry holding register allows back-to-back frames with no idle gap, and the block sits directly in front of the line driver in the TX path.

## Interface
- `OVERSAMPLE`, default 16: `baud_clk` cycles per bit; legal range 4..16.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

- `baud_clk`  in  1  sole clock, running at OVERSAMPLE × baud rate.
- `rst_n`  in  1  reset, synchronous and active-low; sampled only on the `baud_clk` rising edge.
- `tx_data`  in  8  byte to send; must be stable while `tx_valid` is high.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  block can accept a byte this cycle; equals !hold_full.
- `data_tx`  out  1  serial line, registered, idles high.
- `active_flag`  out  1  registered; high from the first start-bit cycle through the last stop-bit cycle.
- `tx_done`  out  1  registered one-cycle pulse on the last cycle of each stop bit.

## Operation
- Accept condition: `tx_valid & tx_ready` at a rising edge.
- Routing of an accepted byte:
  - If the engine is idle, or in the final stop cycle, and the hold register is empty, the byte loads the shift register directly.
  - Otherwise the byte loads the hold register and hold_full is set.
- Frame vector is {stop=1, parity, tx_data[7:0], start=0}, shifted out bit 0 first.
- Parity = ^tx_data ^ PARITY_ODD.
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a direct load.
  - START → DATA after OVERSAMPLE cycles.
  - DATA → PARITY after 8 bits; the bit index is a 3-bit counter that wraps 7→0 on exit.
  - PARITY → STOP after OVERSAMPLE cycles.
  - STOP → START if hold_full or an accept occurs this cycle; otherwise STOP → IDLE.
- Bit timer: counts 0..OVERSAMPLE-1. `data_tx` changes only when the timer wraps.
- On STOP → START from hold, hold_full clears in the same cycle, so `tx_ready` rises the next cycle.
- In IDLE: `data_tx`=1, `active_flag`=0.

## Timing
- Reset values, applied on the first edge with `rst_n`=0: `data_tx`=1, `active_flag`=0, `tx_done`=0, hold_full=0 (so `tx_ready`=1), state=IDLE, timer=0.
- Accept at edge N from IDLE: `data_tx`=0 and `active_flag`=1 from edge N+1.
- Each bit lasts exactly OVERSAMPLE cycles. A frame is 11×OVERSAMPLE cycles (176 at the default).
- `tx_done` is high in cycle N+11×OVERSAMPLE, which is the final stop cycle.
- Back-to-back: the next start bit begins on the edge immediately after the final stop cycle. `active_flag` stays high; `tx_done` still pulses once per frame.
- `tx_ready` low while the hold register is full. `tx_valid` held high while not ready must not be lost or duplicated.
- Simultaneous accept and final stop cycle with hold empty: the byte loads the shift register directly, with zero gap.
- Reset mid-frame: the frame is truncated and `data_tx` returns to 1 on the reset edge. The pending hold byte is discarded and no `tx_done` is issued.
- Changing `tx_data` after acceptance has no effect on the frame in flight.

## Structure
- `uart_pkg` holds:
  - `FRAME_BITS`=11 and `DATA_BITS`=8, shared with the SIPO receiver.
  - The default oversample of 16.
  - The TX state enum.
- One sub-module, `uart_bit_timer`: OVERSAMPLE-modulo counter with synchronous clear and a `bit_end` output. The receiver can reuse it later.
- Shift register, hold register, and FSM are in `uart_tx_piso`.

## Test plan
- Reset, then tx_data=0xA5, tx_valid one cycle, even parity → `data_tx` bits 0,1,0,1,0,0,1,0,1,0,1, each held 16 cycles; `tx_done` at cycle 176; then idle high.
- tx_data=0x01 with PARITY_ODD=0, then with PARITY_ODD=1 → parity bit 1, then 0.
- `tx_valid` held high with 0x55, 0xAA, 0x0F → three contiguous 176-cycle frames with no idle cycles; `tx_ready` low while hold is full; exactly three `tx_done` pulses.
- Loopback into the SIPO receiver on the same `baud_clk` with 0x3C → receiver `data_parll` = {1, 0, 0x3C, 0}.
- Assert `rst_n` low at cycle 80 of a frame while a byte is held → `data_tx`=1 and `tx_ready`=1 after the reset edge; no `tx_done`; the held byte is never transmitted.
- OVERSAMPLE=4 with 0xFF → 44-cycle frame; parity 0 (even); `tx_done` at cycle 44.
